cgra_mem_port_arbiter: RTL

//  Upstream stage of the CGRA SRAM bank wrapper: arbitrates NUM_MASTERS OBI-style request ports onto
//  the single bank port (req/we/addr/wdata/be/set_retentive_n).
//  - Round-robin grant.
//  - Generates OBI rvalid/rdata one cycle after grant, returning sram_rdata_i to the granted master.
//  - Optionally drives bank retention after an idle period.

---
 rtl/cgra_mem_arb_pkg.sv | 31 +++
 rtl/cgra_rr_arbiter.sv | 81 ++++++++
 rtl/cgra_mem_port_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cgra_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// cgra_mem_arb_pkg
// Shared types and defaults for the CGRA SRAM bank port arbiter.
//   obi_req_t       : one master's request fields (we, byte addr, wdata, be)
//   *_DEF           : default parameter values for the arbiter
//   clog2_min1()    : ceil(log2(n)) clamped to at least 1, used for index and
//                     address widths so single-entry configurations still
//                     get a legal one-bit vector
// -----------------------------------------------------------------------------
package cgra_mem_arb_pkg;

    localparam int NUM_MASTERS_DEF     = 2;
    localparam int NUM_WORDS_DEF       = 1024;
    localparam int RET_IDLE_CYCLES_DEF = 64;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } obi_req_t;

    function automatic int clog2_min1(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/cgra_rr_arbiter.sv
// -----------------------------------------------------------------------------
// cgra_rr_arbiter
// Round-robin arbiter: the search starts at the rotating pointer and wraps
// modulo NUM_MASTERS; the first requester wins. The grant is combinational.
// The pointer moves to (winner + 1) only when a grant is actually issued.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset (pointer -> 0)
//   i_req        : request vector
//   i_en         : grant enable; when low no grant is issued, pointer holds
//   o_gnt        : one-hot grant (all zero when nothing is granted)
//   o_idx        : index of the search winner (valid when o_valid)
//   o_valid      : a grant is issued this cycle
// -----------------------------------------------------------------------------
module cgra_rr_arbiter
    import cgra_mem_arb_pkg::*;
#(
    parameter int NUM_MASTERS = NUM_MASTERS_DEF
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [NUM_MASTERS-1:0]             i_req,
    input  logic                               i_en,
    output logic [NUM_MASTERS-1:0]             o_gnt,
    output logic [clog2_min1(NUM_MASTERS)-1:0] o_idx,
    output logic                               o_valid
);

    localparam int IDX_W = clog2_min1(NUM_MASTERS);

    logic [IDX_W-1:0]       r_ptr;
    logic [IDX_W:0]         w_sum;
    logic [IDX_W-1:0]       w_cand;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_found;
    logic [NUM_MASTERS-1:0] w_gnt;

    // Rotating priority search: candidate = (ptr + k) mod NUM_MASTERS.
    always_comb begin
        w_sum   = '0;
        w_cand  = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_MASTERS)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_MASTERS);
            end else begin
                w_sum = w_sum;
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end else begin
                w_found = w_found;
            end
        end
        if (w_found && i_en) begin
            w_gnt[w_idx] = 1'b1;
        end else begin
            w_gnt = '0;
        end
    end

    // Pointer advances past the winner only on an issued grant.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (w_found && i_en) begin
            r_ptr <= (w_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : (w_idx + IDX_W'(1));
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign o_gnt   = w_gnt;
    assign o_idx   = w_idx;
    assign o_valid = w_found & i_en;

endmodule

// File: rtl/cgra_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// cgra_mem_port_arbiter
// Arbitrates NUM_MASTERS OBI-style request ports onto one SRAM bank port.
// Round-robin grant (same cycle), bank signals muxed from the winner, and an
// OBI response (rvalid + rdata) to the granted master one cycle later.
// Optional feature macro: CGRA_MEM_ARB_RET_CTRL_EN
//   defined   : after RET_IDLE_CYCLES request-free cycles the bank is put in
//               retention; the first request afterwards spends one wake cycle
//               (no grant) while retention is released.
//   undefined : sram_set_retentive_no is tied high, no wake cycle.
// Ports:
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   m_req_i/m_gnt_o        : per-master request / same-cycle grant
//   m_we_i, m_addr_i,
//   m_wdata_i, m_be_i      : per-master request fields (32-bit lanes)
//   m_rvalid_o, m_rdata_o  : per-master response (rdata 0 for writes)
//   sram_*_o               : bank request port
//   sram_set_retentive_no  : bank retention control, active-low
//   sram_rdata_i           : bank read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module cgra_mem_port_arbiter
    import cgra_mem_arb_pkg::*;
#(
    parameter int NUM_MASTERS     = NUM_MASTERS_DEF,
    parameter int NUM_WORDS       = NUM_WORDS_DEF,
    parameter int RET_IDLE_CYCLES = RET_IDLE_CYCLES_DEF
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_MASTERS-1:0]           m_req_i,
    output logic [NUM_MASTERS-1:0]           m_gnt_o,
    input  logic [NUM_MASTERS-1:0]           m_we_i,
    input  logic [NUM_MASTERS*32-1:0]        m_addr_i,
    input  logic [NUM_MASTERS*32-1:0]        m_wdata_i,
    input  logic [NUM_MASTERS*4-1:0]         m_be_i,
    output logic [NUM_MASTERS-1:0]           m_rvalid_o,
    output logic [NUM_MASTERS*32-1:0]        m_rdata_o,
    output logic                             sram_req_o,
    output logic                             sram_we_o,
    output logic [clog2_min1(NUM_WORDS)-1:0] sram_addr_o,
    output logic [31:0]                      sram_wdata_o,
    output logic [3:0]                       sram_be_o,
    output logic                             sram_set_retentive_no,
    input  logic [31:0]                      sram_rdata_i
);

    localparam int AW    = clog2_min1(NUM_WORDS);
    localparam int IDX_W = clog2_min1(NUM_MASTERS);

    obi_req_t               w_reqs [NUM_MASTERS];
    obi_req_t               w_sel;
    logic [NUM_MASTERS-1:0] w_gnt;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_gnt_valid;
    logic                   w_gnt_en;
    logic                   w_wake;
    logic                   w_unused;
    logic [NUM_MASTERS-1:0] r_rvalid;
    logic                   r_rsp_we;

    // Gather each master's flat lanes into a request record.
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_reqs[i] = '{we:    m_we_i[i],
                          addr:  m_addr_i[i*32 +: 32],
                          wdata: m_wdata_i[i*32 +: 32],
                          be:    m_be_i[i*4 +: 4]};
        end
    end

    // Grants are blocked during reset and during the retention wake cycle.
    assign w_gnt_en = ~rst_i & ~w_wake;

    cgra_rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_rr (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_req   (m_req_i),
        .i_en    (w_gnt_en),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_valid (w_gnt_valid)
    );

    assign w_sel        = w_reqs[w_idx];
    assign m_gnt_o      = w_gnt;
    assign sram_req_o   = w_gnt_valid;
    assign sram_we_o    = w_sel.we;
    // Byte address -> word index; upper bits drop out so addresses wrap.
    assign sram_addr_o  = w_sel.addr[AW+1:2];
    assign sram_wdata_o = w_sel.wdata;
    assign sram_be_o    = w_sel.be;

    // Response stage: remember who was granted and whether it was a write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= '0;
            r_rsp_we <= 1'b0;
        end else begin
            r_rvalid <= w_gnt;
            r_rsp_we <= w_sel.we;
        end
    end

    assign m_rvalid_o = r_rvalid;

    // Bank read data arrives this cycle; steer it to the responding master only.
    always_comb begin
        m_rdata_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_rvalid[i] && !r_rsp_we) begin
                m_rdata_o[i*32 +: 32] = sram_rdata_i;
            end else begin
                m_rdata_o[i*32 +: 32] = 32'h0000_0000;
            end
        end
    end

`ifdef CGRA_MEM_ARB_RET_CTRL_EN
    localparam int CNT_W = clog2_min1(RET_IDLE_CYCLES + 1);

    logic [CNT_W-1:0] r_idle_cnt;
    logic [CNT_W-1:0] w_idle_nxt;
    logic             r_ret_n;

    // Idle counter: cleared by any request, saturates at the threshold.
    always_comb begin
        if (|m_req_i) begin
            w_idle_nxt = '0;
        end else if (r_idle_cnt == CNT_W'(RET_IDLE_CYCLES)) begin
            w_idle_nxt = r_idle_cnt;
        end else begin
            w_idle_nxt = r_idle_cnt + CNT_W'(1);
        end
    end

    // Retention is entered exactly when the counter sits at the threshold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_idle_cnt <= '0;
            r_ret_n    <= 1'b1;
        end else begin
            r_idle_cnt <= w_idle_nxt;
            r_ret_n    <= (w_idle_nxt != CNT_W'(RET_IDLE_CYCLES));
        end
    end

    // A request seen while retentive is the wake cycle: retention releases at
    // the next edge and this cycle carries no grant.
    assign w_wake                = ~r_ret_n & (|m_req_i);
    assign sram_set_retentive_no = r_ret_n;
`else
    assign w_wake                = 1'b0;
    assign sram_set_retentive_no = 1'b1;
`endif

    // Address bits outside the word index are intentionally ignored.
    assign w_unused = ^{w_sel.addr[31:AW+2], w_sel.addr[1:0], (RET_IDLE_CYCLES > 0)};

endmodule
